// File: rtl/rs_simple.sv
// rs_simple: two-entry reservation station in front of the simple ALU (ex_simple).
// It holds dispatched 114-bit RS entries and wakes their operands from two CDBs.
// The FU frees an entry by pulsing simple_0_issue or simple_1_issue.
// Optional feature, off by default: RS_CDB_BYPASS_EN.
//   When RS_CDB_BYPASS_EN is defined, the entry outputs show a CDB wakeup in the
//   same cycle as the broadcast.
//   Otherwise the outputs come only from registers.
module rs_simple #(
    parameter int ENTRY_W = 114,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               disp_valid_0,
    input  logic               disp_valid_1,
    input  logic [ENTRY_W-1:0] disp_inst_0,
    input  logic [ENTRY_W-1:0] disp_inst_1,
    input  logic [TAG_W-1:0]   disp_rob_num_0,
    input  logic [TAG_W-1:0]   disp_rob_num_1,
    output logic [1:0]         free_count,
    input  logic               cdb_a_valid,
    input  logic [TAG_W-1:0]   cdb_a_rob_num,
    input  logic [DATA_W-1:0]  cdb_a_data,
    input  logic               cdb_b_valid,
    input  logic [TAG_W-1:0]   cdb_b_rob_num,
    input  logic [DATA_W-1:0]  cdb_b_data,
    input  logic               simple_0_issue,
    input  logic               simple_1_issue,
    output logic [ENTRY_W-1:0] rs_simple_0,
    output logic [ENTRY_W-1:0] rs_simple_1,
    output logic [TAG_W-1:0]   rs_simple_0_entry_num,
    output logic [TAG_W-1:0]   rs_simple_1_entry_num,
    output logic               selector
);

    // Bit positions of the operand fields inside an RS entry.
    localparam int S1_V   = 5;
    localparam int S1_LSB = 6;
    localparam int S2_V   = 38;
    localparam int S2_LSB = 39;

    logic [1:0]         r_busy;
    logic [ENTRY_W-1:0] r_inst [2];
    logic [TAG_W-1:0]   r_rob  [2];
    logic               r_selector;
    logic [1:0]         r_free_count;

    logic [1:0]         w_issue;
    logic               w_l0_ok, w_l1_ok;
    logic               w_l0_idx, w_l1_idx;
    logic [1:0]         w_avail_l1;
    logic [1:0]         w_nx_busy;
    logic [ENTRY_W-1:0] w_nx_inst [2];
    logic [TAG_W-1:0]   w_nx_rob  [2];
    logic               w_nx_selector;
    logic [1:0]         w_nx_free_count;
    logic [ENTRY_W-1:0] w_out [2];

    // Applies a CDB wakeup to each operand that is still waiting.
    // A waiting operand carries its producer tag in the low bits of its value field.
    // If both buses match, bus A takes priority.
    function automatic logic [ENTRY_W-1:0] f_wake(
        input logic [ENTRY_W-1:0] inst,
        input logic               a_v,
        input logic [TAG_W-1:0]   a_tag,
        input logic [DATA_W-1:0]  a_data,
        input logic               b_v,
        input logic [TAG_W-1:0]   b_tag,
        input logic [DATA_W-1:0]  b_data
    );
        logic [ENTRY_W-1:0] res;
        res = inst;
        if (!inst[S1_V]) begin
            if (a_v && inst[S1_LSB +: TAG_W] == a_tag) begin
                res[S1_LSB +: DATA_W] = a_data;
                res[S1_V]             = 1'b1;
            end else if (b_v && inst[S1_LSB +: TAG_W] == b_tag) begin
                res[S1_LSB +: DATA_W] = b_data;
                res[S1_V]             = 1'b1;
            end
        end
        if (!inst[S2_V]) begin
            if (a_v && inst[S2_LSB +: TAG_W] == a_tag) begin
                res[S2_LSB +: DATA_W] = a_data;
                res[S2_V]             = 1'b1;
            end else if (b_v && inst[S2_LSB +: TAG_W] == b_tag) begin
                res[S2_LSB +: DATA_W] = b_data;
                res[S2_V]             = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_issue = {simple_1_issue, simple_0_issue};

    // Assigns the dispatch lanes to entries that are free at the start of the cycle.
    // An entry freed by an issue this cycle is not yet available.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_l0_ok    = 1'b0;
        w_l0_idx   = 1'b0;
        w_l1_ok    = 1'b0;
        w_l1_idx   = 1'b0;
        w_avail_l1 = ~r_busy;
        if (disp_valid_0) begin
            if (!r_busy[0]) begin
                w_l0_ok  = 1'b1;
                w_l0_idx = 1'b0;
            end else if (!r_busy[1]) begin
                w_l0_ok  = 1'b1;
                w_l0_idx = 1'b1;
            end
        end
        if (w_l0_ok) w_avail_l1[w_l0_idx] = 1'b0;
        if (disp_valid_1) begin
            if (w_avail_l1[0]) begin
                w_l1_ok  = 1'b1;
                w_l1_idx = 1'b0;
            end else if (w_avail_l1[1]) begin
                w_l1_ok  = 1'b1;
                w_l1_idx = 1'b1;
            end
        end
    end

    // Next-state logic: wakeup of held entries, issue, dispatch, selector and free count.
    always_comb begin
        for (int e = 0; e < 2; e++) begin
            w_nx_busy[e] = r_busy[e] & ~w_issue[e];
            w_nx_inst[e] = r_busy[e] ? f_wake(r_inst[e], cdb_a_valid, cdb_a_rob_num, cdb_a_data,
                                              cdb_b_valid, cdb_b_rob_num, cdb_b_data)
                                     : r_inst[e];
            w_nx_rob[e]  = r_rob[e];
        end
        w_nx_selector = r_selector;
        if (w_l0_ok) begin
            w_nx_busy[w_l0_idx] = 1'b1;
            w_nx_inst[w_l0_idx] = f_wake(disp_inst_0, cdb_a_valid, cdb_a_rob_num, cdb_a_data,
                                         cdb_b_valid, cdb_b_rob_num, cdb_b_data);
            w_nx_rob[w_l0_idx]  = disp_rob_num_0;
            w_nx_selector       = w_l0_idx;
        end
        if (w_l1_ok) begin
            w_nx_busy[w_l1_idx] = 1'b1;
            w_nx_inst[w_l1_idx] = f_wake(disp_inst_1, cdb_a_valid, cdb_a_rob_num, cdb_a_data,
                                         cdb_b_valid, cdb_b_rob_num, cdb_b_data);
            w_nx_rob[w_l1_idx]  = disp_rob_num_1;
            w_nx_selector       = w_l1_idx;
        end
        w_nx_free_count = {1'b0, ~w_nx_busy[0]} + {1'b0, ~w_nx_busy[1]};
    end

    // State registers. A flush clears everything, just like reset.
    always_ff @(posedge clk) begin
        // NOTE: the entry storage is only two words, so it is cleared on reset along with
        // the busy bits. That keeps entry_num and the selector at 0 after reset.
        if (rst || flush) begin
            r_busy       <= '0;
            r_selector   <= 1'b0;
            r_free_count <= 2'd2;
            for (int e = 0; e < 2; e++) begin
                r_inst[e] <= '0;
                r_rob[e]  <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every register
            // samples the same pre-edge values.
            r_busy       <= w_nx_busy;
            r_selector   <= w_nx_selector;
            r_free_count <= w_nx_free_count;
            for (int e = 0; e < 2; e++) begin
                r_inst[e] <= w_nx_inst[e];
                r_rob[e]  <= w_nx_rob[e];
            end
        end
    end

    // Entry outputs. An empty entry reads as all-zero, so the FU never selects it.
    always_comb begin
        for (int e = 0; e < 2; e++) begin
            w_out[e] = '0;
            if (r_busy[e]) begin
`ifdef RS_CDB_BYPASS_EN
                w_out[e] = f_wake(r_inst[e], cdb_a_valid, cdb_a_rob_num, cdb_a_data,
                                  cdb_b_valid, cdb_b_rob_num, cdb_b_data);
`else
                w_out[e] = r_inst[e];
`endif
            end
        end
    end

    assign rs_simple_0           = w_out[0];
    assign rs_simple_1           = w_out[1];
    assign rs_simple_0_entry_num = r_rob[0];
    assign rs_simple_1_entry_num = r_rob[1];
    assign selector              = r_selector;
    assign free_count            = r_free_count;

endmodule

// File: tb/tb_rs_simple.sv
// tb_rs_simple: directed, table-driven bench for the rs_simple reservation station.
// Each vector is driven at a falling edge and takes effect on the rising edge.
// Inputs then return to idle, and outputs are checked at the next falling edge.
module tb_rs_simple;

    logic         clk = 1'b0;
    logic         rst, flush;
    logic         disp_valid_0, disp_valid_1;
    logic [113:0] disp_inst_0, disp_inst_1;
    logic [3:0]   disp_rob_num_0, disp_rob_num_1;
    logic [1:0]   free_count;
    logic         cdb_a_valid, cdb_b_valid;
    logic [3:0]   cdb_a_rob_num, cdb_b_rob_num;
    logic [31:0]  cdb_a_data, cdb_b_data;
    logic         simple_0_issue, simple_1_issue;
    logic [113:0] rs_simple_0, rs_simple_1;
    logic [3:0]   rs_simple_0_entry_num, rs_simple_1_entry_num;
    logic         selector;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rs_simple dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid_0(disp_valid_0), .disp_valid_1(disp_valid_1),
        .disp_inst_0(disp_inst_0), .disp_inst_1(disp_inst_1),
        .disp_rob_num_0(disp_rob_num_0), .disp_rob_num_1(disp_rob_num_1),
        .free_count(free_count),
        .cdb_a_valid(cdb_a_valid), .cdb_a_rob_num(cdb_a_rob_num), .cdb_a_data(cdb_a_data),
        .cdb_b_valid(cdb_b_valid), .cdb_b_rob_num(cdb_b_rob_num), .cdb_b_data(cdb_b_data),
        .simple_0_issue(simple_0_issue), .simple_1_issue(simple_1_issue),
        .rs_simple_0(rs_simple_0), .rs_simple_1(rs_simple_1),
        .rs_simple_0_entry_num(rs_simple_0_entry_num),
        .rs_simple_1_entry_num(rs_simple_1_entry_num),
        .selector(selector)
    );

    typedef struct packed {
        logic         flush;
        logic         dv0, dv1;
        logic [113:0] di0, di1;
        logic [3:0]   dr0, dr1;
        logic         av;
        logic [3:0]   ar;
        logic [31:0]  ad;
        logic         bv;
        logic [3:0]   br;
        logic [31:0]  bd;
        logic         is0, is1;
        logic [113:0] o0, o1;
        logic [3:0]   e0, e1;
        logic         sel;
        logic [1:0]   fc;
    } vec_t;

    localparam int NV = 10;
    vec_t tv [NV];

    // Builds an RS entry: {hi[42:0], s2, s2_valid, s1, s1_valid, rd}.
    function automatic logic [113:0] mk(input logic [4:0] rd, input logic s1v, input logic [31:0] s1,
                                        input logic s2v, input logic [31:0] s2, input logic [42:0] hi);
        return {hi, s2, s2v, s1, s1v, rd};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; flush = 1'b0;
        disp_valid_0 = 1'b0; disp_valid_1 = 1'b0;
        disp_inst_0 = '0; disp_inst_1 = '0; disp_rob_num_0 = '0; disp_rob_num_1 = '0;
        cdb_a_valid = 1'b0; cdb_a_rob_num = '0; cdb_a_data = '0;
        cdb_b_valid = 1'b0; cdb_b_rob_num = '0; cdb_b_data = '0;
        simple_0_issue = 1'b0; simple_1_issue = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        flush = v.flush;
        disp_valid_0 = v.dv0; disp_inst_0 = v.di0; disp_rob_num_0 = v.dr0;
        disp_valid_1 = v.dv1; disp_inst_1 = v.di1; disp_rob_num_1 = v.dr1;
        cdb_a_valid = v.av; cdb_a_rob_num = v.ar; cdb_a_data = v.ad;
        cdb_b_valid = v.bv; cdb_b_rob_num = v.br; cdb_b_data = v.bd;
        simple_0_issue = v.is0; simple_1_issue = v.is1;
    endtask

    // Clocks one edge, returns the inputs to idle and ends at the next falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        set_idle();
        @(negedge clk);
    endtask

    logic [42:0]  hi_a, hi_b, hi_c, hi_d;
    logic [113:0] inst_a, inst_b, inst_bw, inst_c, inst_d, inst_dw1, inst_dw2, inst_e, inst_ew;
    logic [113:0] inst_f, inst_fw;

    initial begin
        hi_a = 43'h0AB_CDEF_0123;
        hi_b = 43'h512_3456_789A;
        hi_c = 43'h7FF_0000_FFFF;
        hi_d = 43'h155_5555_5555;
        inst_a   = mk(5'd1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, hi_a);
        inst_b   = mk(5'd2, 1'b0, 32'h0000_0007, 1'b1, 32'h0000_0300, hi_b);
        inst_bw  = mk(5'd2, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0300, hi_b);
        inst_c   = mk(5'd3, 1'b1, 32'h0000_0005, 1'b1, 32'h0000_0006, hi_c);
        inst_d   = mk(5'd4, 1'b0, 32'h0000_0007, 1'b0, 32'h0000_0009, hi_d);
        inst_dw1 = mk(5'd4, 1'b1, 32'h0000_0011, 1'b0, 32'h0000_0009, hi_d);
        inst_dw2 = mk(5'd4, 1'b1, 32'h0000_0011, 1'b1, 32'h0000_0040, hi_d);
        inst_e   = mk(5'd5, 1'b0, 32'h0000_0009, 1'b1, 32'h0000_0077, hi_a);
        inst_ew  = mk(5'd5, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0077, hi_a);
        inst_f   = mk(5'd6, 1'b0, 32'h0000_0007, 1'b1, 32'h0000_0001, hi_b);
        inst_fw  = mk(5'd6, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0000_0001, hi_b);

        for (int i = 0; i < NV; i++) tv[i] = '0;
        // 0: idle after reset, so the RS is empty.
        tv[0].fc = 2'd2;
        // 1: both lanes dispatch. A goes to entry 0 and B to entry 1.
        tv[1].dv0 = 1; tv[1].di0 = inst_a; tv[1].dr0 = 4'd3;
        tv[1].dv1 = 1; tv[1].di1 = inst_b; tv[1].dr1 = 4'd5;
        tv[1].o0 = inst_a; tv[1].o1 = inst_b; tv[1].e0 = 4'd3; tv[1].e1 = 4'd5;
        tv[1].sel = 1; tv[1].fc = 2'd0;
        // 2: CDB A broadcasts rob 7, which wakes s1 of entry 1.
        tv[2].av = 1; tv[2].ar = 4'd7; tv[2].ad = 32'hDEAD_BEEF;
        tv[2].o0 = inst_a; tv[2].o1 = inst_bw; tv[2].e0 = 4'd3; tv[2].e1 = 4'd5;
        tv[2].sel = 1; tv[2].fc = 2'd0;
        // 3: RS is full. Issue 1 plus dispatch in the same cycle, so the dispatch is dropped.
        tv[3].is1 = 1; tv[3].dv0 = 1; tv[3].di0 = inst_c; tv[3].dr0 = 4'd9;
        tv[3].o0 = inst_a; tv[3].e0 = 4'd3; tv[3].sel = 1; tv[3].fc = 2'd1;
        // 4: the retried dispatch fills entry 1.
        tv[4].dv0 = 1; tv[4].di0 = inst_c; tv[4].dr0 = 4'd9;
        tv[4].o0 = inst_a; tv[4].o1 = inst_c; tv[4].e0 = 4'd3; tv[4].e1 = 4'd9;
        tv[4].sel = 1; tv[4].fc = 2'd0;
        // 5: both entries issue. The RS empties and the selector holds.
        tv[5].is0 = 1; tv[5].is1 = 1; tv[5].sel = 1; tv[5].fc = 2'd2;
        // 6: D dispatches with both operands waiting (tags 7 and 9).
        tv[6].dv0 = 1; tv[6].di0 = inst_d; tv[6].dr0 = 4'd2;
        tv[6].o0 = inst_d; tv[6].e0 = 4'd2; tv[6].sel = 0; tv[6].fc = 2'd1;
        // 7: CDB A and CDB B both broadcast rob 7, so A's data (0x11) wins.
        tv[7].av = 1; tv[7].ar = 4'd7; tv[7].ad = 32'h11;
        tv[7].bv = 1; tv[7].br = 4'd7; tv[7].bd = 32'h22;
        tv[7].o0 = inst_dw1; tv[7].e0 = 4'd2; tv[7].sel = 0; tv[7].fc = 2'd1;
        // 8: CDB B rob 9 wakes the stored s2 of D and also wakes s1 of E while E dispatches.
        tv[8].bv = 1; tv[8].br = 4'd9; tv[8].bd = 32'h40;
        tv[8].av = 1; tv[8].ar = 4'd3; tv[8].ad = 32'h99;
        tv[8].dv0 = 1; tv[8].di0 = inst_e; tv[8].dr0 = 4'd4;
        tv[8].o0 = inst_dw2; tv[8].o1 = inst_ew; tv[8].e0 = 4'd2; tv[8].e1 = 4'd4;
        tv[8].sel = 1; tv[8].fc = 2'd0;
        // 9: flush with a concurrent dispatch and broadcast. Everything ends up empty.
        tv[9].flush = 1; tv[9].dv0 = 1; tv[9].di0 = inst_c; tv[9].dr0 = 4'd9;
        tv[9].av = 1; tv[9].ar = 4'd7; tv[9].ad = 32'h1;
        tv[9].sel = 0; tv[9].fc = 2'd2;

        // Reset for two cycles with a dispatch request held. Reset must win.
        set_idle();
        rst = 1'b1;
        disp_valid_0 = 1'b1; disp_inst_0 = inst_a; disp_rob_num_0 = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        set_idle();
        @(negedge clk);
        check("reset rs_simple_0", 128'(rs_simple_0), 128'(0));
        check("reset rs_simple_1", 128'(rs_simple_1), 128'(0));
        check("reset entry_num_0", 128'(rs_simple_0_entry_num), 128'(0));
        check("reset entry_num_1", 128'(rs_simple_1_entry_num), 128'(0));
        check("reset selector", 128'(selector), 128'(0));
        check("reset free_count", 128'(free_count), 128'(2));

        for (int i = 0; i < NV; i++) begin
            drive(tv[i]);
            step();
            check($sformatf("v%0d rs_simple_0", i), 128'(rs_simple_0), 128'(tv[i].o0));
            check($sformatf("v%0d rs_simple_1", i), 128'(rs_simple_1), 128'(tv[i].o1));
            check($sformatf("v%0d selector", i), 128'(selector), 128'(tv[i].sel));
            check($sformatf("v%0d free_count", i), 128'(free_count), 128'(tv[i].fc));
            // The ROB number is meaningful only while the entry is occupied.
            if (tv[i].o0 != '0)
                check($sformatf("v%0d entry_num_0", i), 128'(rs_simple_0_entry_num), 128'(tv[i].e0));
            if (tv[i].o1 != '0)
                check($sformatf("v%0d entry_num_1", i), 128'(rs_simple_1_entry_num), 128'(tv[i].e1));
        end
        check("flush entry_num_0", 128'(rs_simple_0_entry_num), 128'(0));
        check("flush entry_num_1", 128'(rs_simple_1_entry_num), 128'(0));

        // Same-cycle wakeup visibility: F waits on tag 7, then CDB A broadcasts rob 7.
        disp_valid_0 = 1'b1; disp_inst_0 = inst_f; disp_rob_num_0 = 4'd6;
        step();
        check("f dispatched", 128'(rs_simple_0), 128'(inst_f));
        check("f free_count", 128'(free_count), 128'(1));
        cdb_a_valid = 1'b1; cdb_a_rob_num = 4'd7; cdb_a_data = 32'hCAFE_F00D;
        #1;
`ifdef RS_CDB_BYPASS_EN
        check("bypass same cycle", 128'(rs_simple_0), 128'(inst_fw));
`else
        check("no bypass same cycle", 128'(rs_simple_0), 128'(inst_f));
`endif
        step();
        check("f woken next cycle", 128'(rs_simple_0), 128'(inst_fw));
        check("f entry_num", 128'(rs_simple_0_entry_num), 128'(6));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
